// File: rtl/uart_sdram_seq.sv
// uart_sdram_seq: sequencer for the UART -> SDRAM -> UART loopback path.
// Bytes from the receiver are written into the SDRAM write port. After a
// settle delay the same window is read back, and the read FIFO is drained
// to the transmitter at a paced rate. Each burst advances a rolling address
// window that wraps back to zero near ADDR_DEPTH.
module uart_sdram_seq #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 24,
    parameter int unsigned       LEN_W      = 10,
    parameter logic [LEN_W-1:0]  MAX_LEN    = 10'd512,
    // One bit wider than ADDR_W so that the full 2^ADDR_W depth is representable.
    parameter logic [ADDR_W:0]   ADDR_DEPTH = 25'd16_777_216,
    parameter logic [15:0]       WAIT_MAX   = 16'd769,
    parameter logic [16:0]       TX_GAP     = 17'd52080,
    parameter logic [23:0]       RX_TIMEOUT = 24'd500_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              rx_flag,
    input  logic [DATA_W-1:0] rx_data,
    output logic              wr_req,
    output logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] wr_b_addr,
    output logic [ADDR_W-1:0] wr_e_addr,
    output logic              read_valid,
    output logic [ADDR_W-1:0] rd_b_addr,
    output logic [ADDR_W-1:0] rd_e_addr,
    output logic [LEN_W-1:0]  burst_len,
    input  logic [LEN_W-1:0]  rd_fifo_num,
    output logic              rd_req,
    input  logic [15:0]       rd_data,
    output logic              tx_flag,
    output logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              ovf_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W:0]   CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    // A zero request still moves one byte; oversize requests are clamped.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req);
        logic [LEN_W-1:0] res;
        if (req == {LEN_W{1'b0}}) begin
            res = LEN_ONE;
        end else if (req > MAX_LEN) begin
            res = MAX_LEN;
        end else begin
            res = req;
        end
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W:0]      cnt_q, cnt_d;
    logic [23:0]         idle_q, idle_d;
    logic [15:0]         wait_q, wait_d;
    logic [16:0]         gap_q, gap_d;
    logic [LEN_W:0]      pop_q, pop_d;
    logic [LEN_W:0]      tx_cnt_q, tx_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   e_addr_q, e_addr_d;
    logic                read_valid_q, read_valid_d;
    logic                rd_req_q, rd_req_d;
    logic                rd_dv_q, rd_dv_d;
    logic                tx_flag_q, tx_flag_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;

    logic [LEN_W-1:0]    len_cfg_s;
    logic [LEN_W:0]      cnt_inc_s;
    logic [23:0]         idle_inc_s;
    logic                idle_hit_s;
    logic                wait_done_s;
    logic                fifo_ready_s;
    logic                gap_wrap_s;
    logic                drain_done_s;
    logic                accept_s;
    logic [ADDR_W+1:0]   base_ext_s;
    logic [ADDR_W+1:0]   len_ext_s;
    logic [ADDR_W-1:0]   base_next_s;
    logic                unused_rd_s;

    assign len_cfg_s    = clamp_len(cfg_len);
    assign cnt_inc_s    = cnt_q + CNT_ONE;
    assign idle_inc_s   = (idle_q == 24'hFF_FFFF) ? idle_q : (idle_q + 24'd1);
    assign idle_hit_s   = (idle_inc_s == RX_TIMEOUT);
    assign wait_done_s  = ((wait_q + 16'd1) == WAIT_MAX);
    assign fifo_ready_s = (rd_fifo_num >= len_q);
    assign gap_wrap_s   = ((gap_q + 17'd1) == TX_GAP);
    assign drain_done_s = tx_flag_q && (tx_cnt_q == {1'b0, len_q});
    assign accept_s     = (state_q == ST_IDLE) || (state_q == ST_FILL);

    // Window advance: restart at zero when the following window would not fit.
    assign base_ext_s  = {2'b00, base_q};
    assign len_ext_s   = {{(ADDR_W+2-LEN_W){1'b0}}, len_q};
    assign base_next_s = ((base_ext_s + len_ext_s + len_ext_s) > {1'b0, ADDR_DEPTH}) ?
                         {ADDR_W{1'b0}} : (base_q + len_ext_s[ADDR_W-1:0]);

    // Only the low byte of the read FIFO word carries UART data.
    assign unused_rd_s = ^rd_data[15:DATA_W];

    // State register and all datapath flops, synchronous active-high reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            len_q        <= LEN_ONE;
            cnt_q        <= {(LEN_W+1){1'b0}};
            idle_q       <= 24'd0;
            wait_q       <= 16'd0;
            gap_q        <= 17'd0;
            pop_q        <= {(LEN_W+1){1'b0}};
            tx_cnt_q     <= {(LEN_W+1){1'b0}};
            base_q       <= {ADDR_W{1'b0}};
            e_addr_q     <= {{(ADDR_W-1){1'b0}}, 1'b1};
            read_valid_q <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_dv_q      <= 1'b0;
            tx_flag_q    <= 1'b0;
            tx_data_q    <= {DATA_W{1'b0}};
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            wait_q       <= wait_d;
            gap_q        <= gap_d;
            pop_q        <= pop_d;
            tx_cnt_q     <= tx_cnt_d;
            base_q       <= base_d;
            e_addr_q     <= e_addr_d;
            read_valid_q <= read_valid_d;
            rd_req_q     <= rd_req_d;
            rd_dv_q      <= rd_dv_d;
            tx_flag_q    <= tx_flag_d;
            tx_data_q    <= tx_data_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_flag) begin
                    if (len_cfg_s == LEN_ONE) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                // A byte arriving on the timeout cycle wins over the timeout.
                if (rx_flag) begin
                    if (cnt_inc_s == {1'b0, len_q}) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else if (idle_hit_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WAIT: begin
                if (wait_done_s) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_READ: begin
                if (fifo_ready_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values, driven by the current state.
    always_comb begin
        len_d        = len_q;
        cnt_d        = cnt_q;
        idle_d       = 24'd0;
        wait_d       = 16'd0;
        gap_d        = 17'd0;
        pop_d        = pop_q;
        tx_cnt_d     = tx_cnt_q;
        base_d       = base_q;
        read_valid_d = 1'b0;
        rd_req_d     = 1'b0;
        // Read FIFO data is valid the cycle after a pop; capture it then.
        rd_dv_d      = rd_req_q;
        tx_flag_d    = rd_dv_q;
        tx_data_d    = rd_dv_q ? rd_data[DATA_W-1:0] : tx_data_q;
        ovf_d        = ovf_q | (rx_flag & ~accept_s);
        case (state_q)
            ST_IDLE: begin
                if (rx_flag) begin
                    len_d = len_cfg_s;
                    cnt_d = CNT_ONE;
                end else begin
                    len_d = len_q;
                end
            end
            ST_FILL: begin
                if (rx_flag) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    idle_d = idle_inc_s;
                    if (idle_hit_s) begin
                        len_d = cnt_q[LEN_W-1:0];
                    end else begin
                        len_d = len_q;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_done_s) begin
                    read_valid_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_READ: begin
                if (fifo_ready_s) begin
                    // First pop goes out on the first DRAIN cycle.
                    rd_req_d = 1'b1;
                    pop_d    = CNT_ONE;
                    tx_cnt_d = {(LEN_W+1){1'b0}};
                end else begin
                    read_valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (gap_wrap_s) begin
                    gap_d = 17'd0;
                    if (pop_q < {1'b0, len_q}) begin
                        rd_req_d = 1'b1;
                        pop_d    = pop_q + CNT_ONE;
                    end else begin
                        rd_req_d = 1'b0;
                    end
                end else begin
                    gap_d = gap_q + 17'd1;
                end
                if (rd_dv_q) begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end else begin
                    tx_cnt_d = tx_cnt_q;
                end
                if (drain_done_s) begin
                    base_d = base_next_s;
                end else begin
                    base_d = base_q;
                end
            end
            default: begin
                len_d = len_q;
            end
        endcase
        e_addr_d = base_d + {{(ADDR_W-LEN_W){1'b0}}, len_d};
        busy_d   = (state_d != ST_IDLE);
    end

    assign wr_req     = rx_flag && accept_s;
    assign wr_data    = {{(16-DATA_W){1'b0}}, rx_data};
    assign wr_b_addr  = base_q;
    assign wr_e_addr  = e_addr_q;
    assign rd_b_addr  = base_q;
    assign rd_e_addr  = e_addr_q;
    assign burst_len  = len_q;
    assign read_valid = read_valid_q;
    assign rd_req     = rd_req_q;
    assign tx_flag    = tx_flag_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign ovf_err    = ovf_q;

endmodule
